seg7_scan_driver: RTL and testbench
===================================

Name: seg7_scan_driver

Overview:
Parametrised, time-multiplexed driver for an N-digit common-anode seven-segment display. It replaces the per-digit combinational BCD decode and the 3-8 digit-select decode with one sequential block: prescaler, digit scan counter, tear-free double-buffered value load and registered active-low outputs. It sits between the datapath (BCD/hex value producer) and the board display pins.

Parameters:
NUM_DIGITS, 4, number of digits scanned (1..8); width of dig_n and dp_in.
CLK_DIV, 50000, clk cycles per digit slot (>=2).
HEX_MODE, 1, 1: nibbles 10-15 show A,b,C,d,E,F. 0: nibbles 10-15 show blank.

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
load  in  1  one-cycle strobe; capture data_in/dp_in into shadow register
data_in  in  4*NUM_DIGITS  digit values; nibble i = digit i, digit 0 = least significant
dp_in  in  NUM_DIGITS  decimal point per digit, 1 = lit
en  in  1  1 = display on; 0 = all digits dark, scanning continues
seg_n  out  7  segments, active-low, seg_n[6]=a .. seg_n[0]=g
dp_n  out  1  decimal point, active-low
dig_n  out  NUM_DIGITS  digit enables, active-low, one-cold
pending  out  1  shadow holds data not yet shown
frame_done  out  1  one-cycle pulse at each frame wrap

Behaviour:
- Reset (async, rst_n=0): prescaler=0, idx=0, shadow=0, display=0, pending=0. Outputs: seg_n=7'h7F, dp_n=1, dig_n=all 1, frame_done=0.
- Prescaler counts 0..CLK_DIV-1 and wraps. tick=1 in the cycle it equals CLK_DIV-1.
- On tick, idx advances by 1 modulo NUM_DIGITS. A wrap is tick with idx==NUM_DIGITS-1.
- Outputs are registered, 1-cycle latency from idx/display/en. Each cycle:
  - dig_n = ~(1<<idx) if en, else all 1.
  - seg_n = glyph(display nibble idx), forced to 7'h7F when en=0.
  - dp_n = ~dp bit idx, forced to 1 when en=0.
- Glyphs, active-low, a..g: 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100. Hex: A=0001000, b=1100000, C=0110001, d=1000010, E=0110000, F=0111000. Blank=1111111.
- Load: load=1 writes shadow<=data_in and dp_in, and sets pending=1. A second load before commit overwrites the shadow; the last value wins.
- Commit at wrap: if pending, display<=shadow and pending<=0. frame_done=1 for exactly that cycle, whether or not a commit happened. This guarantees no mid-frame tearing.
- Load in the same cycle as wrap: data_in bypasses the shadow and is committed directly; shadow<=data_in; pending=0.
- NUM_DIGITS=1: every tick is a wrap.
- Reset mid-frame: all state returns to reset values immediately. Any pending data is lost.

Optional Feature:
SEG7_LEADING_ZERO_BLANK_EN.
- Defined: contiguous zero nibbles from digit NUM_DIGITS-1 downward are shown blank (seg_n=7'h7F); their dp is still honoured. Digit 0 is never blanked. The blank mask is computed from the display register.
- Undefined: every nibble is decoded as-is, so zeros show "0".

Decomposition:
- Package seg7_pkg holds:
  - the 16 glyph constants plus SEG_BLANK=7'h7F;
  - the segment-width constant;
  - the function for a clog2-based idx width.
- Sub-module seg7_glyph_rom: combinational 4-bit to 7-bit lookup with HEX_MODE parameter. Instantiated once on the selected nibble.

Test Plan:
1. NUM_DIGITS=4, CLK_DIV=4, reset release, en=1 -> dig_n cycles 1110,1101,1011,0111, each held 4 clk. seg_n=7'b0000001 on all digits. frame_done pulses every 16 clk.
2. load data_in=16'h1234, dp_in=4'b0010 mid-frame -> pending=1. Old value shown until wrap. Next frame shows 4,3,2,1 on digits 0..3 with dp_n=0 on digit 1 only. pending=0 after wrap.
3. load 16'hABCD, then 16'h5678 before wrap -> only 5678 is ever displayed. HEX_MODE=0 with 16'hFA09 -> digits 3,2 blank, digit 1 "0", digit 0 "9".
4. load coincident with wrap tick -> value shown from idx 0 of the very next frame; pending stays 0.
5. en=0 for 10 clk -> dig_n=1111, seg_n=7'h7F, dp_n=1; idx keeps advancing. After en=1 the scan resumes at the correct phase.
6. With SEG7_LEADING_ZERO_BLANK_EN, display 16'h0040 -> digit 3 blank, digit 2 blank, digit 1 "4", digit 0 "0". Assert rst_n=0 mid-frame -> outputs reset immediately.

Source files
------------

// File: rtl/seg7_pkg.sv
// -----------------------------------------------------------------------------
// seg7_pkg
// Shared constants for the seven-segment scan driver:
//   - SEG_W      : number of segment lines (a..g)
//   - SEG_BLANK  : all segments dark (active-low)
//   - GLYPH_0..F : active-low glyphs, bit 6 = a .. bit 0 = g
//   - idx_width(): width of the digit scan index for a given digit count
// Optional feature macro used by the driver: SEG7_LEADING_ZERO_BLANK_EN
// -----------------------------------------------------------------------------
package seg7_pkg;

    localparam int SEG_W = 7;

    localparam logic [SEG_W-1:0] SEG_BLANK = 7'h7F;

    localparam logic [SEG_W-1:0] GLYPH_0 = 7'b0000001;
    localparam logic [SEG_W-1:0] GLYPH_1 = 7'b1001111;
    localparam logic [SEG_W-1:0] GLYPH_2 = 7'b0010010;
    localparam logic [SEG_W-1:0] GLYPH_3 = 7'b0000110;
    localparam logic [SEG_W-1:0] GLYPH_4 = 7'b1001100;
    localparam logic [SEG_W-1:0] GLYPH_5 = 7'b0100100;
    localparam logic [SEG_W-1:0] GLYPH_6 = 7'b0100000;
    localparam logic [SEG_W-1:0] GLYPH_7 = 7'b0001111;
    localparam logic [SEG_W-1:0] GLYPH_8 = 7'b0000000;
    localparam logic [SEG_W-1:0] GLYPH_9 = 7'b0000100;
    localparam logic [SEG_W-1:0] GLYPH_A = 7'b0001000;
    localparam logic [SEG_W-1:0] GLYPH_B = 7'b1100000;
    localparam logic [SEG_W-1:0] GLYPH_C = 7'b0110001;
    localparam logic [SEG_W-1:0] GLYPH_D = 7'b1000010;
    localparam logic [SEG_W-1:0] GLYPH_E = 7'b0110000;
    localparam logic [SEG_W-1:0] GLYPH_F = 7'b0111000;

    // A single digit still needs a 1-bit index so the counter is never zero-width.
    function automatic int idx_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/seg7_glyph_rom.sv
// -----------------------------------------------------------------------------
// seg7_glyph_rom
// Combinational 4-bit nibble to active-low 7-segment glyph lookup.
// Parameters:
//   HEX_MODE : 1 = nibbles 10..15 show A,b,C,d,E,F; 0 = they show blank
// Ports:
//   nibble_i : value to display
//   seg_n_o  : active-low segments, bit 6 = a .. bit 0 = g
// -----------------------------------------------------------------------------
module seg7_glyph_rom
    import seg7_pkg::*;
#(
    parameter int HEX_MODE = 1
) (
    input  logic [3:0]       nibble_i,
    output logic [SEG_W-1:0] seg_n_o
);

    localparam bit HEX_ON = (HEX_MODE != 0);

    // Nibble to glyph lookup; letters collapse to blank when hex is disabled.
    always_comb begin
        seg_n_o = SEG_BLANK;
        case (nibble_i)
            4'h0:    seg_n_o = GLYPH_0;
            4'h1:    seg_n_o = GLYPH_1;
            4'h2:    seg_n_o = GLYPH_2;
            4'h3:    seg_n_o = GLYPH_3;
            4'h4:    seg_n_o = GLYPH_4;
            4'h5:    seg_n_o = GLYPH_5;
            4'h6:    seg_n_o = GLYPH_6;
            4'h7:    seg_n_o = GLYPH_7;
            4'h8:    seg_n_o = GLYPH_8;
            4'h9:    seg_n_o = GLYPH_9;
            4'hA:    seg_n_o = HEX_ON ? GLYPH_A : SEG_BLANK;
            4'hB:    seg_n_o = HEX_ON ? GLYPH_B : SEG_BLANK;
            4'hC:    seg_n_o = HEX_ON ? GLYPH_C : SEG_BLANK;
            4'hD:    seg_n_o = HEX_ON ? GLYPH_D : SEG_BLANK;
            4'hE:    seg_n_o = HEX_ON ? GLYPH_E : SEG_BLANK;
            4'hF:    seg_n_o = HEX_ON ? GLYPH_F : SEG_BLANK;
            default: seg_n_o = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// -----------------------------------------------------------------------------
// seg7_scan_driver
// Time-multiplexed driver for an N-digit common-anode seven-segment display.
// A prescaler defines digit slots of CLK_DIV clocks; the scan index steps one
// digit per slot. New values are captured into a shadow register on `load` and
// only copied into the displayed register at the frame wrap, so a frame never
// mixes old and new digits.
//
// Parameters: NUM_DIGITS (1..8), CLK_DIV (>=2), HEX_MODE (1 = show A..F).
// Optional feature macro: SEG7_LEADING_ZERO_BLANK_EN
//   defined   -> leading zero digits (from the top digit downward, never digit 0)
//                are blanked; their decimal point is still shown.
//   undefined -> every digit is decoded as-is.
//
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   load        : one-cycle strobe capturing data_in/dp_in
//   data_in     : 4 bits per digit, digit 0 in the low nibble
//   dp_in       : decimal point per digit, 1 = lit
//   en          : 1 = display on, 0 = all dark (scan keeps running)
//   seg_n, dp_n : active-low segment and decimal point lines
//   dig_n       : active-low one-cold digit enables
//   pending     : shadow holds data not yet shown
//   frame_done  : one-cycle pulse in the cycle after each frame wrap, aligned
//                 with the scan index returning to digit 0
// -----------------------------------------------------------------------------
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int CLK_DIV    = 50000,
    parameter int HEX_MODE   = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] data_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic                    en,
    output logic [SEG_W-1:0]        seg_n,
    output logic                    dp_n,
    output logic [NUM_DIGITS-1:0]   dig_n,
    output logic                    pending,
    output logic                    frame_done
);

    localparam int IDX_W  = idx_width(NUM_DIGITS);
    localparam int PRE_W  = $clog2(CLK_DIV);
    localparam int DATA_W = 4 * NUM_DIGITS;

    localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(CLK_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(NUM_DIGITS - 1);

    logic [PRE_W-1:0]      presc_q,      presc_d;
    logic [IDX_W-1:0]      idx_q,        idx_d;
    logic [DATA_W-1:0]     shadow_q,     shadow_d;
    logic [NUM_DIGITS-1:0] shadow_dp_q,  shadow_dp_d;
    logic [DATA_W-1:0]     disp_q,       disp_d;
    logic [NUM_DIGITS-1:0] disp_dp_q,    disp_dp_d;
    logic                  pending_q,    pending_d;
    logic [SEG_W-1:0]      seg_n_q,      seg_n_d;
    logic                  dp_n_q,       dp_n_d;
    logic [NUM_DIGITS-1:0] dig_n_q,      dig_n_d;
    logic                  frame_done_q, frame_done_d;

    logic                  tick_s;
    logic                  wrap_s;
    logic [NUM_DIGITS-1:0] sel_s;
    logic [3:0]            nib_s;
    logic                  dp_sel_s;
    logic                  blank_sel_s;
    logic [NUM_DIGITS-1:0] lz_mask_s;
    logic [SEG_W-1:0]      glyph_s;

    // Prescaler and scan index; a wrap is the last slot's last clock.
    always_comb begin
        tick_s = (presc_q == PRE_MAX);
        wrap_s = tick_s && (idx_q == IDX_MAX);
        if (tick_s) begin
            presc_d = '0;
        end else begin
            presc_d = presc_q + PRE_W'(1);
        end
        if (!tick_s) begin
            idx_d = idx_q;
        end else if (idx_q == IDX_MAX) begin
            idx_d = '0;
        end else begin
            idx_d = idx_q + IDX_W'(1);
        end
    end

    // Shadow capture and commit; a load on the wrap cycle goes straight to display.
    always_comb begin
        shadow_d    = shadow_q;
        shadow_dp_d = shadow_dp_q;
        disp_d      = disp_q;
        disp_dp_d   = disp_dp_q;
        pending_d   = pending_q;
        if (load) begin
            shadow_d    = data_in;
            shadow_dp_d = dp_in;
            if (wrap_s) begin
                disp_d    = data_in;
                disp_dp_d = dp_in;
                pending_d = 1'b0;
            end else begin
                pending_d = 1'b1;
            end
        end else if (wrap_s && pending_q) begin
            disp_d    = shadow_q;
            disp_dp_d = shadow_dp_q;
            pending_d = 1'b0;
        end else begin
            pending_d = pending_q;
        end
    end

`ifdef SEG7_LEADING_ZERO_BLANK_EN
    logic lz_run_s;

    // Walk down from the top digit; a digit is blank while every digit above it is zero too.
    always_comb begin
        lz_run_s  = 1'b1;
        lz_mask_s = '0;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            lz_run_s     = lz_run_s & (disp_q[4*i +: 4] == 4'h0);
            lz_mask_s[i] = lz_run_s;
        end
    end
`else
    assign lz_mask_s = '0;
`endif

    // One-hot select of the current digit, then AND-OR mux of nibble, dp and blank flag.
    always_comb begin
        nib_s       = 4'h0;
        dp_sel_s    = 1'b0;
        blank_sel_s = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            sel_s[i]    = (idx_q == IDX_W'(i));
            nib_s       = nib_s | ({4{sel_s[i]}} & disp_q[4*i +: 4]);
            dp_sel_s    = dp_sel_s | (sel_s[i] & disp_dp_q[i]);
            blank_sel_s = blank_sel_s | (sel_s[i] & lz_mask_s[i]);
        end
    end

    seg7_glyph_rom #(
        .HEX_MODE (HEX_MODE)
    ) u_glyph_rom (
        .nibble_i (nib_s),
        .seg_n_o  (glyph_s)
    );

    // Next value of the registered pin drivers; en=0 darkens everything.
    always_comb begin
        seg_n_d      = (en && !blank_sel_s) ? glyph_s : SEG_BLANK;
        dp_n_d       = ~(en & dp_sel_s);
        frame_done_d = wrap_s;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            dig_n_d[i] = ~(en & sel_s[i]);
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q      <= '0;
            idx_q        <= '0;
            shadow_q     <= '0;
            shadow_dp_q  <= '0;
            disp_q       <= '0;
            disp_dp_q    <= '0;
            pending_q    <= 1'b0;
            seg_n_q      <= SEG_BLANK;
            dp_n_q       <= 1'b1;
            dig_n_q      <= '1;
            frame_done_q <= 1'b0;
        end else begin
            presc_q      <= presc_d;
            idx_q        <= idx_d;
            shadow_q     <= shadow_d;
            shadow_dp_q  <= shadow_dp_d;
            disp_q       <= disp_d;
            disp_dp_q    <= disp_dp_d;
            pending_q    <= pending_d;
            seg_n_q      <= seg_n_d;
            dp_n_q       <= dp_n_d;
            dig_n_q      <= dig_n_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign seg_n      = seg_n_q;
    assign dp_n       = dp_n_q;
    assign dig_n      = dig_n_q;
    assign pending    = pending_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// -----------------------------------------------------------------------------
// tb_seg7_scan_driver
// Two drivers (HEX_MODE=1 and HEX_MODE=0) share one stimulus stream. A reference
// model derives the scanned digit from a cycle count since reset, pushes the
// expected pin values for every clock into a queue, and a monitor pops and
// compares one entry after each rising edge.
// -----------------------------------------------------------------------------
module tb_seg7_scan_driver;

    localparam int ND    = 4;
    localparam int CD    = 4;
    localparam int FRAME = ND * CD;

    localparam logic [6:0] GTAB [0:15] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };

    typedef struct packed {
        logic [6:0]    seg_h;
        logic [6:0]    seg_b;
        logic          dp;
        logic [ND-1:0] dig;
        logic          pend;
        logic          fd;
    } exp_t;

    logic          clk;
    logic          rst_n;
    logic          load;
    logic [4*ND-1:0] data_in;
    logic [ND-1:0] dp_in;
    logic          en;

    logic [6:0]    seg_n_h, seg_n_b;
    logic          dp_n_h, dp_n_b;
    logic [ND-1:0] dig_n_h, dig_n_b;
    logic          pend_h, pend_b;
    logic          fd_h, fd_b;

    int n_checks = 0;
    int n_fail   = 0;

    exp_t exp_q[$];
    exp_t mon_e;

    // reference model state
    int          m_cyc;
    logic [15:0] m_shown;
    logic [3:0]  m_shown_dp;
    logic        m_pend;
    logic [15:0] m_pend_val;
    logic [3:0]  m_pend_dp;

    seg7_scan_driver #(.NUM_DIGITS(ND), .CLK_DIV(CD), .HEX_MODE(1)) dut_h (
        .clk(clk), .rst_n(rst_n), .load(load), .data_in(data_in), .dp_in(dp_in),
        .en(en), .seg_n(seg_n_h), .dp_n(dp_n_h), .dig_n(dig_n_h),
        .pending(pend_h), .frame_done(fd_h)
    );

    seg7_scan_driver #(.NUM_DIGITS(ND), .CLK_DIV(CD), .HEX_MODE(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .load(load), .data_in(data_in), .dp_in(dp_in),
        .en(en), .seg_n(seg_n_b), .dp_n(dp_n_b), .dig_n(dig_n_b),
        .pending(pend_b), .frame_done(fd_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t, cyc=%0d)", name, act, expv, $time, m_cyc);
        end
    endtask

    function automatic logic [6:0] glyph(input logic [3:0] n, input bit hex);
        if (!hex && n > 4'd9) return 7'h7F;
        return GTAB[n];
    endfunction

    task automatic model_reset();
        m_cyc      = 0;
        m_shown    = 16'h0;
        m_shown_dp = 4'h0;
        m_pend     = 1'b0;
        m_pend_val = 16'h0;
        m_pend_dp  = 4'h0;
        exp_q.delete();
    endtask

    // Drive one clock worth of inputs, record what the next rising edge must produce.
    task automatic step(input logic ld, input logic [15:0] d, input logic [3:0] dp, input logic e);
        exp_t x;
        int   slot;
        bit   wrap;
        bit   blank;
        logic [3:0] nib;
        load    = ld;
        data_in = d;
        dp_in   = dp;
        en      = e;
        slot  = (m_cyc / CD) % ND;
        wrap  = ((m_cyc % FRAME) == FRAME - 1);
        nib   = 4'(m_shown >> (4 * slot));
        blank = 1'b0;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
        blank = (slot != 0) && ((m_shown >> (4 * slot)) == 16'h0);
`endif
        x.dig   = e ? ~(4'b0001 << slot) : 4'hF;
        x.seg_h = (!e || blank) ? 7'h7F : glyph(nib, 1'b1);
        x.seg_b = (!e || blank) ? 7'h7F : glyph(nib, 1'b0);
        x.dp    = e ? ~m_shown_dp[slot] : 1'b1;
        x.fd    = wrap;
        if (ld) begin
            m_pend_val = d;
            m_pend_dp  = dp;
            if (wrap) begin
                m_shown    = d;
                m_shown_dp = dp;
                m_pend     = 1'b0;
            end else begin
                m_pend = 1'b1;
            end
        end else if (wrap && m_pend) begin
            m_shown    = m_pend_val;
            m_shown_dp = m_pend_dp;
            m_pend     = 1'b0;
        end
        x.pend = m_pend;
        exp_q.push_back(x);
        m_cyc++;
        @(negedge clk);
    endtask

    task automatic idle();
        step(1'b0, 16'h0, 4'h0, 1'b1);
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_seg_h"}, 16'(seg_n_h), 16'h7F);
        chk({tag, "_seg_b"}, 16'(seg_n_b), 16'h7F);
        chk({tag, "_dp_h"},  16'(dp_n_h),  16'h1);
        chk({tag, "_dp_b"},  16'(dp_n_b),  16'h1);
        chk({tag, "_dig_h"}, 16'(dig_n_h), 16'hF);
        chk({tag, "_dig_b"}, 16'(dig_n_b), 16'hF);
        chk({tag, "_pend_h"}, 16'(pend_h), 16'h0);
        chk({tag, "_pend_b"}, 16'(pend_b), 16'h0);
        chk({tag, "_fd_h"},  16'(fd_h),    16'h0);
        chk({tag, "_fd_b"},  16'(fd_b),    16'h0);
    endtask

    // Monitor: one expectation per rising edge while out of reset.
    always @(posedge clk) begin
        #1;
        if (rst_n && exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            chk("seg_hex",   16'(seg_n_h), 16'(mon_e.seg_h));
            chk("seg_nohex", 16'(seg_n_b), 16'(mon_e.seg_b));
            chk("dp_hex",    16'(dp_n_h),  16'(mon_e.dp));
            chk("dp_nohex",  16'(dp_n_b),  16'(mon_e.dp));
            chk("dig_hex",   16'(dig_n_h), 16'(mon_e.dig));
            chk("dig_nohex", 16'(dig_n_b), 16'(mon_e.dig));
            chk("pend_hex",  16'(pend_h),  16'(mon_e.pend));
            chk("pend_nohex",16'(pend_b),  16'(mon_e.pend));
            chk("fd_hex",    16'(fd_h),    16'(mon_e.fd));
            chk("fd_nohex",  16'(fd_b),    16'(mon_e.fd));
        end
    end

    initial begin
        int off_left;
        logic [15:0] rd;
        rst_n   = 1'b0;
        load    = 1'b0;
        data_in = 16'h0;
        dp_in   = 4'h0;
        en      = 1'b1;
        model_reset();
        repeat (3) @(negedge clk);
        check_reset("por");
        rst_n = 1'b1;

        // free-running scan of all-zero display
        repeat (40) idle();
        // mid-frame load with one decimal point
        step(1'b1, 16'h1234, 4'b0010, 1'b1);
        repeat (40) idle();
        // overwrite before commit: only the last value may appear
        step(1'b1, 16'hABCD, 4'b0001, 1'b1);
        repeat (2) idle();
        step(1'b1, 16'h5678, 4'b1000, 1'b1);
        repeat (40) idle();
        step(1'b1, 16'hFA09, 4'b0000, 1'b1);
        repeat (40) idle();
        // load exactly on the wrap cycle
        while ((m_cyc % FRAME) != FRAME - 1) idle();
        step(1'b1, 16'h9E07, 4'b0100, 1'b1);
        repeat (20) idle();
        // display off for 10 clocks, scan keeps its phase
        repeat (10) step(1'b0, 16'h0, 4'h0, 1'b0);
        repeat (20) idle();
        // leading zeros
        step(1'b1, 16'h0040, 4'b1000, 1'b1);
        repeat (40) idle();

        // randomized traffic
        off_left = 0;
        for (int i = 0; i < 2000; i++) begin
            for (int k = 0; k < 4; k++) begin
                rd[4*k +: 4] = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
            end
            if (off_left == 0 && $urandom_range(0, 63) == 0) off_left = $urandom_range(1, 12);
            step(($urandom_range(0, 7) == 0), rd, 4'($urandom_range(0, 15)), (off_left == 0));
            if (off_left > 0) off_left--;
        end

        // asynchronous reset in the middle of a frame with data pending
        step(1'b1, 16'h4321, 4'b0101, 1'b1);
        while ((m_cyc % FRAME) != 6) idle();
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset("midrst");
        @(negedge clk);
        @(negedge clk);
        model_reset();
        rst_n = 1'b1;
        repeat (40) idle();

        @(posedge clk);
        #3;
        chk("queue_drained", 16'(exp_q.size()), 16'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
